// File: rtl/mem_map_if.sv
// CPU-side multiplexed bus bundle shared by the address decoder and its bus master.
interface mem_map_if #(
   parameter int NUM_REGIONS = 4
);
   logic                   ALE;
   logic                   IOMn;
   logic                   RDn;
   logic                   WRn;
   logic [7:0]             haddress;
   logic [7:0]             laddress_data;
   logic [15:0]            address;
   logic [NUM_REGIONS-1:0] CSn;
   logic                   READY;
   logic [2:0]             region;
   logic                   unmapped;
   logic                   bus_err;

   modport master (
      output ALE, IOMn, RDn, WRn, haddress, laddress_data,
      input  address, CSn, READY, region, unmapped, bus_err
   );

   modport slave (
      input  ALE, IOMn, RDn, WRn, haddress, laddress_data,
      output address, CSn, READY, region, unmapped, bus_err
   );
endinterface

// File: rtl/mem_map_ctrl.sv
// ALE-latched address decoder driving per-region chip selects and READY wait states.
// Optional bus watchdog enabled by defining BUS_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | no cycle in progress, all CSn high, READY high
// ST_ADDR   | address latched, CSn asserted, waiting for RDn/WRn strobe
// ST_WAIT   | wait states counting down, READY low
// ST_ACTIVE | strobe phase, READY high, until both strobes released
module mem_map_ctrl #(
   parameter int                       NUM_REGIONS    = 4,
   parameter logic [NUM_REGIONS*8-1:0] REGION_BASE    = {8'h03, 8'h02, 8'h01, 8'h00},
   parameter logic [NUM_REGIONS*8-1:0] REGION_MASK    = {NUM_REGIONS{8'hFF}},
   parameter logic [NUM_REGIONS-1:0]   REGION_IO      = '0,
   parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT    = '0,
   parameter int                       TIMEOUT_CYCLES = 64
) (
   input logic      clk,
   input logic      rst,
   mem_map_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT, ST_ACTIVE} state_t;

   state_t      state_q, state_d;
   logic [15:0] address_q, address_d;
   logic [2:0]  region_q, region_d;
   logic        unmapped_q, unmapped_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;

   logic                   hit;
   logic [2:0]             hit_idx;
   logic [3:0]             wait_sel;
   logic                   strobe;
   logic [NUM_REGIONS-1:0] cs_n;

   assign strobe = !bus.RDn || !bus.WRn;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (((bus.haddress & REGION_MASK[i*8 +: 8]) == (REGION_BASE[i*8 +: 8] & REGION_MASK[i*8 +: 8]))
             && (bus.IOMn == REGION_IO[i])) begin
            hit     = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   always_comb begin
      wait_sel = '0;
      if (!unmapped_q) begin
         for (int i = 0; i < NUM_REGIONS; i++) begin
            if (region_q == 3'(i)) wait_sel = REGION_WAIT[i*4 +: 4];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
         cs_n[i] = !((state_q != ST_IDLE) && !unmapped_q && (region_q == 3'(i)));
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             bus_err_q, bus_err_d;
`endif

   always_comb begin
      state_d    = state_q;
      address_d  = address_q;
      region_d   = region_q;
      unmapped_d = unmapped_q;
      wait_cnt_d = wait_cnt_q;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_d  = '0;
      bus_err_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: ;
         ST_ADDR: begin
            if (strobe) begin
               if (wait_sel == 4'd0) begin
                  state_d = ST_ACTIVE;
               end else begin
                  wait_cnt_d = wait_sel;
                  state_d    = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == 4'd1) begin
               wait_cnt_d = '0;
               state_d    = ST_ACTIVE;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         ST_ACTIVE: begin
            if (!strobe) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef BUS_TIMEOUT_EN
      if (state_q != ST_IDLE) begin
         if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            bus_err_d  = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end
`endif
      // ALE restarts from any state and overrides the watchdog.
      if (bus.ALE) begin
         address_d  = {bus.haddress, bus.laddress_data};
         region_d   = hit ? hit_idx : 3'd0;
         unmapped_d = !hit;
         wait_cnt_d = '0;
         state_d    = ST_ADDR;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt_d  = '0;
         bus_err_d  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         address_q  <= '0;
         region_q   <= '0;
         unmapped_q <= 1'b0;
         wait_cnt_q <= '0;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt_q  <= '0;
         bus_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         address_q  <= address_d;
         region_q   <= region_d;
         unmapped_q <= unmapped_d;
         wait_cnt_q <= wait_cnt_d;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt_q  <= tmo_cnt_d;
         bus_err_q  <= bus_err_d;
`endif
      end
   end

   assign bus.address  = address_q;
   assign bus.CSn      = cs_n;
   assign bus.READY    = (state_q != ST_WAIT);
   assign bus.region   = region_q;
   assign bus.unmapped = unmapped_q;
`ifdef BUS_TIMEOUT_EN
   assign bus.bus_err  = bus_err_q;
`else
   // No watchdog in this build: constant low.
   assign bus.bus_err  = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Scoreboard bench for mem_map_ctrl: decode, wait states, ALE restart, reset abort, watchdog.
module tb_mem_map_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_map_if #(.NUM_REGIONS(4)) bus ();

   mem_map_ctrl #(
      .NUM_REGIONS    (4),
      .REGION_BASE    ({8'h03, 8'h02, 8'h01, 8'h00}),
      .REGION_MASK    ({8'hFF, 8'hFE, 8'hFF, 8'hFF}),
      .REGION_IO      (4'b1000),
      .REGION_WAIT    ({4'd2, 4'd3, 4'd0, 4'd0}),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [15:0] addr;
      logic [3:0]  csn;
      logic [2:0]  region;
      logic        unmapped;
      int          waits;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // stb bit0 = RDn low, bit1 = WRn low
   task automatic run_access(input logic [7:0] h, input logic [7:0] l, input logic iom,
                             input logic [1:0] stb, input logic [2:0] er, input logic eu,
                             input logic [3:0] ecsn, input int ew);
      exp_t e;
      exp_t got;
      int   n;
      bit   done;
      e.addr     = {h, l};
      e.csn      = ecsn;
      e.region   = er;
      e.unmapped = eu;
      e.waits    = ew;
      sb_q.push_back(e);
      @(negedge clk);
      bus.ALE = 1'b1; bus.haddress = h; bus.laddress_data = l; bus.IOMn = iom;
      @(negedge clk);
      bus.ALE = 1'b0; bus.laddress_data = 8'hEE;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         got = sb_q.pop_front();
         chk("addr", 32'(bus.address), 32'(got.addr));
         chk("region", 32'(bus.region), 32'(got.region));
         chk("unmapped", 32'(bus.unmapped), 32'(got.unmapped));
         chk("csn_addr", 32'(bus.CSn), 32'(got.csn));
         chk("ready_addr", 32'(bus.READY), 32'd1);
         bus.RDn = !stb[0];
         bus.WRn = !stb[1];
         n = 0;
         done = 1'b0;
         for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.READY) done = 1'b1;
            else n++;
         end
         chk("ready_return", 32'(done), 32'd1);
         chk("wait_cycles", 32'(n), 32'(got.waits));
         chk("csn_active", 32'(bus.CSn), 32'(got.csn));
         bus.RDn = 1'b1;
         bus.WRn = 1'b1;
         @(negedge clk);
         chk("csn_idle", 32'(bus.CSn), 32'hF);
         chk("ready_idle", 32'(bus.READY), 32'd1);
         chk("addr_hold", 32'(bus.address), 32'(got.addr));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      int k_err;
      bit seen;
      rst = 1'b1;
      bus.ALE = 1'b0; bus.IOMn = 1'b0; bus.RDn = 1'b1; bus.WRn = 1'b1;
      bus.haddress = 8'h00; bus.laddress_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_addr", 32'(bus.address), 32'h0000);
      chk("rst_csn", 32'(bus.CSn), 32'hF);
      chk("rst_ready", 32'(bus.READY), 32'd1);
      chk("rst_region", 32'(bus.region), 32'd0);
      chk("rst_unmapped", 32'(bus.unmapped), 32'd0);
      chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_access(8'h01, 8'h34, 1'b0, 2'b01, 3'd1, 1'b0, 4'b1101, 0);
      run_access(8'h02, 8'h56, 1'b0, 2'b01, 3'd2, 1'b0, 4'b1011, 3);
      run_access(8'h80, 8'h00, 1'b0, 2'b01, 3'd0, 1'b1, 4'b1111, 0);
      run_access(8'h03, 8'h77, 1'b0, 2'b10, 3'd2, 1'b0, 4'b1011, 3);
      run_access(8'h03, 8'h9A, 1'b1, 2'b01, 3'd3, 1'b0, 4'b0111, 2);
      run_access(8'h01, 8'hBC, 1'b1, 2'b11, 3'd0, 1'b1, 4'b1111, 0);
      run_access(8'h00, 8'h11, 1'b0, 2'b11, 3'd0, 1'b0, 4'b1110, 0);
      run_access(8'h00, 8'h22, 1'b1, 2'b01, 3'd0, 1'b1, 4'b1111, 0);

      // ALE restart while counting wait states
      @(negedge clk);
      bus.ALE = 1'b1; bus.haddress = 8'h02; bus.laddress_data = 8'h10; bus.IOMn = 1'b0;
      @(negedge clk);
      bus.ALE = 1'b0; bus.RDn = 1'b0;
      @(negedge clk);
      chk("restart_in_wait", 32'(bus.READY), 32'd0);
      bus.ALE = 1'b1; bus.haddress = 8'h00; bus.laddress_data = 8'h20;
      @(negedge clk);
      bus.ALE = 1'b0;
      chk("restart_csn", 32'(bus.CSn), 32'hE);
      chk("restart_ready", 32'(bus.READY), 32'd1);
      chk("restart_addr", 32'(bus.address), 32'h0020);
      chk("restart_region", 32'(bus.region), 32'd0);
      @(negedge clk);
      chk("restart_active_ready", 32'(bus.READY), 32'd1);
      chk("restart_active_csn", 32'(bus.CSn), 32'hE);
      bus.RDn = 1'b1;
      @(negedge clk);
      chk("restart_idle_csn", 32'(bus.CSn), 32'hF);

      // reset while in WAIT
      bus.ALE = 1'b1; bus.haddress = 8'h02; bus.laddress_data = 8'h30;
      @(negedge clk);
      bus.ALE = 1'b0; bus.RDn = 1'b0;
      @(negedge clk);
      chk("rstwait_in_wait", 32'(bus.READY), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rstwait_ready", 32'(bus.READY), 32'd1);
      chk("rstwait_csn", 32'(bus.CSn), 32'hF);
      chk("rstwait_addr", 32'(bus.address), 32'h0000);
      chk("rstwait_bus_err", 32'(bus.bus_err), 32'd0);
      chk("rstwait_region", 32'(bus.region), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rstwait_stays_idle", 32'(bus.CSn), 32'hF);
      bus.RDn = 1'b1;
      @(negedge clk);

      // strobe held low indefinitely
      bus.ALE = 1'b1; bus.haddress = 8'h01; bus.laddress_data = 8'h40; bus.IOMn = 1'b0;
      @(negedge clk);
      bus.ALE = 1'b0; bus.RDn = 1'b0;
`ifdef BUS_TIMEOUT_EN
      seen = 1'b0;
      k_err = 0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         if (bus.bus_err) begin
            seen = 1'b1;
            k_err = k;
         end
      end
      chk("tmo_seen", 32'(seen), 32'd1);
      chk("tmo_latency", 32'(k_err), 32'd8);
      chk("tmo_csn", 32'(bus.CSn), 32'hF);
      chk("tmo_ready", 32'(bus.READY), 32'd1);
      @(negedge clk);
      chk("tmo_pulse_width", 32'(bus.bus_err), 32'd0);
      chk("tmo_idle_csn", 32'(bus.CSn), 32'hF);
`else
      seen = 1'b0;
      k_err = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.bus_err) seen = 1'b1;
      end
      chk("hold_no_bus_err", 32'(seen), 32'd0);
      chk("hold_csn", 32'(bus.CSn), 32'hD);
      chk("hold_ready", 32'(bus.READY), 32'd1);
      chk("hold_k_err", 32'(k_err), 32'd0);
`endif
      bus.RDn = 1'b1;
      @(negedge clk);
      chk("final_idle_csn", 32'(bus.CSn), 32'hF);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_map_ctrl.md
MEM_MAP_CTRL -- requirements
Module: mem_map_ctrl

Interface
REQ-001 Parameter NUM_REGIONS, 4, number of decoded chip-select regions (1..8).
REQ-002 Parameter REGION_BASE, {8'h03,8'h02,8'h01,8'h00}, packed NUM_REGIONS x 8-bit high-address match values; region i uses bits [8i+7:8i].
REQ-003 Parameter REGION_MASK, all 8'hFF, packed NUM_REGIONS x 8-bit compare masks.
REQ-004 Parameter REGION_IO, all 1'b0, packed NUM_REGIONS x 1-bit; region i matches only when latched IOMn equals REGION_IO[i].
REQ-005 Parameter REGION_WAIT, all 4'd0, packed NUM_REGIONS x 4-bit wait-state count per region.
REQ-006 Parameter TIMEOUT_CYCLES, 64, watchdog limit (used only with BUS_TIMEOUT_EN).
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  system clock, all state updates on rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 ALE  in  1  address latch enable from CPU.
REQ-011 IOMn  in  1  1 = I/O cycle, 0 = memory cycle.
REQ-012 RDn  in  1  active-low read strobe.
REQ-013 WRn  in  1  active-low write strobe.
REQ-014 haddress  in  8  high address byte.
REQ-015 laddress_data  in  8  multiplexed low address/data byte (sampled only).
REQ-016 address  out  16  latched address {haddress, laddress_data}.
REQ-017 CSn  out  NUM_REGIONS  active-low chip selects, at most one low.
REQ-018 READY  out  1  1 = CPU may complete cycle.
REQ-019 region  out  3  index of matched region.
REQ-020 unmapped  out  1  latched cycle matched no region.
REQ-021 bus_err  out  1  one-cycle timeout pulse.

Function
REQ-022 FSM states IDLE, ADDR, WAIT, ACTIVE.
REQ-023 Any state, ALE=1 at rising edge: latch address, IOMn, decoded region, unmapped; go to ADDR; an in-progress cycle is abandoned (ALE restart).
REQ-024 Match for region i: (haddress & MASK[i]) == (BASE[i] & MASK[i]) and IOMn == REGION_IO[i]; lowest matching index wins.
REQ-025 No match: unmapped=1, region=0, all CSn high, wait count treated as 0.
REQ-026 ADDR: CSn[region] low (if mapped); READY=1; on strobe (RDn=0 or WRn=0) go ACTIVE if REGION_WAIT=0, else load counter with REGION_WAIT and go WAIT.
REQ-027 WAIT: READY=0, counter decrements each cycle; at counter==1 go ACTIVE, giving exactly REGION_WAIT cycles of READY=0 after strobe sampled.
REQ-028 ACTIVE: READY=1, CSn held; when RDn=1 and WRn=1 go IDLE, CSn all high next cycle.
REQ-029 RDn and WRn simultaneously low: treated as one access, no error.
REQ-030 IDLE: CSn all high, READY=1; address, region, unmapped hold last latched values.
REQ-031 ALE takes priority over every other transition including timeout.

Reset
REQ-032 On rst=1 at rising edge: state IDLE, address 16'h0000, CSn all 1, READY 1, region 0, unmapped 0, bus_err 0, counters 0.
REQ-033 Reset mid-access aborts immediately; no bus_err generated.

Configuration
REQ-034 Macro BUS_TIMEOUT_EN defined: cycle counter runs in ADDR/WAIT/ACTIVE, cleared on ALE; reaching TIMEOUT_CYCLES pulses bus_err for one cycle, forces CSn all high, READY 1, state IDLE.
REQ-035 BUS_TIMEOUT_EN undefined: no watchdog logic, bus_err tied 0, FSM waits indefinitely.

Verification
REQ-036 Defaults, ALE with haddress=8'h01, laddress_data=8'h34, IOMn=0, RDn low -> address=16'h0134, CSn=4'b1101, READY stays 1, region=1.
REQ-037 REGION_WAIT[2]=3, memory read to 8'h02xx -> READY low exactly 3 cycles after RDn sampled low, then 1; CSn=4'b1011 until RDn high.
REQ-038 haddress=8'h80 read -> unmapped=1, CSn=4'b1111, READY=1 throughout.
REQ-039 Second ALE during WAIT to 8'h00xx -> counter abandoned, CSn=4'b1110 next cycle, READY=1 in ADDR.
REQ-040 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, RDn held low indefinitely -> bus_err high one cycle 8 cycles after ALE latch, CSn all high, state IDLE.
REQ-041 rst asserted in WAIT -> next cycle READY=1, CSn all high, address=16'h0000, bus_err=0.
